// File: rtl/vga_pkg.sv
// Shared framebuffer constants and the owner tag used by the arbiter's
// response pipeline.
package vga_pkg;

  localparam int FB_ADDR_WIDTH = 15;
  localparam int FB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_CPU  = 2'd2
  } fb_owner_t;

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Framebuffer arbiter bus bundle: VGA fetch port, CPU MMIO port and RAM port.
// slave = arbiter side, master = requesters plus the RAM macro.
interface vga_fb_arbiter_if
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH
);

  logic                    vga_req;
  logic [ADDR_WIDTH-1:0]   vga_addr;
  logic                    vga_urgent;
  logic                    vga_gnt;
  logic                    vga_rvalid;
  logic [DATA_WIDTH-1:0]   vga_rdata;

  logic                    cpu_req;
  logic                    cpu_we;
  logic [ADDR_WIDTH-1:0]   cpu_addr;
  logic [DATA_WIDTH-1:0]   cpu_wdata;
  logic [DATA_WIDTH/8-1:0] cpu_wstrb;
  logic                    cpu_ack;
  logic [DATA_WIDTH-1:0]   cpu_rdata;

  logic                    mem_en;
  logic [DATA_WIDTH/8-1:0] mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  vga_req, vga_addr, vga_urgent,
    output vga_gnt, vga_rvalid, vga_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_ack, cpu_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output vga_req, vga_addr, vga_urgent,
    input  vga_gnt, vga_rvalid, vga_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_ack, cpu_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/fb_wait_timer.sv
// Saturating 8-bit CPU starvation counter. expired tells the arbiter the
// CPU has been refused long enough to be forced in.
module fb_wait_timer #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  logic [7:0] count;

  // Clear wins over increment; saturate at 255 so a long urgent stall never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= 8'd0;
    else if (inc && (count != 8'hFF))
      count <= count + 8'd1;
  end

  assign expired = (count >= 8'(MAX_WAIT));

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: VGA scanout has priority, the CPU gets a
// forced slot after CPU_MAX_WAIT refusals unless the VGA FIFO is urgent.
// RAM read latency is one cycle; an owner register steers the returning data.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH   = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH   = FB_DATA_WIDTH,
  parameter int CPU_MAX_WAIT = 8
) (
  input logic             clk,
  input logic             rst,
  vga_fb_arbiter_if.slave bus
);

  fb_owner_t owner;
  logic      cpu_pending;
  logic      cpu_eligible;
  logic      wait_expired;
  logic      force_cpu;
  logic      cpu_gnt;
  logic      vga_gnt_w;
  logic      vga_rvalid_w;
  logic      cpu_ack_w;

  // Grant decision is combinational; nothing is granted while in reset.
  always_comb begin
    cpu_eligible = bus.cpu_req && !cpu_pending && !rst;
    force_cpu    = cpu_eligible && wait_expired && !bus.vga_urgent;
    cpu_gnt      = cpu_eligible && (force_cpu || !bus.vga_req);
    vga_gnt_w    = bus.vga_req && !cpu_gnt && !rst;
  end

  assign bus.vga_gnt = vga_gnt_w;

  fb_wait_timer #(
    .MAX_WAIT (CPU_MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .inc     (cpu_eligible && !cpu_gnt),
    .clr     (cpu_gnt),
    .expired (wait_expired)
  );

  // RAM port mux; idle cycles drive zeros so a strobe can never leak through.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (vga_gnt_w) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.vga_addr;
    end else if (cpu_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_we    = bus.cpu_we ? bus.cpu_wstrb : '0;
    end
  end

  // Response side: owner of last cycle's access claims this cycle's RAM data.
  // Gating with rst drops any in-flight response when reset hits mid-transaction.
  assign vga_rvalid_w  = (owner == OWN_VGA) && !rst;
  assign cpu_ack_w     = (owner == OWN_CPU) && !rst;
  assign bus.vga_rvalid = vga_rvalid_w;
  assign bus.cpu_ack    = cpu_ack_w;
  assign bus.vga_rdata  = vga_rvalid_w ? bus.mem_rdata : '0;
  assign bus.cpu_rdata  = cpu_ack_w    ? bus.mem_rdata : '0;

  // Owner tag and CPU pending flag; pending blocks a re-grant in the ack cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= OWN_NONE;
      cpu_pending <= 1'b0;
    end else begin
      if (cpu_gnt)        owner <= OWN_CPU;
      else if (vga_gnt_w) owner <= OWN_VGA;
      else                owner <= OWN_NONE;

      if (cpu_gnt)        cpu_pending <= 1'b1;
      else if (cpu_ack_w) cpu_pending <= 1'b0;
    end
  end

endmodule
